// File: rtl/addsub_issue_stage.sv
`default_nettype none
//==============================================================================
// Module   : addsub_issue_stage
// Purpose  : Operand-issue and result-capture stage around an external
//            combinational 32-bit adder/subtractor. Two pipeline stages:
//              E - registered operands driven to the adder (add_a/add_b/add_m)
//              R - captured adder result awaiting writeback
//            Operands are selected from the register file, the immediate, or
//            forwarded from E (live adder output) or R (captured result).
// Ports    :
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid / in_ready           decode-side handshake
//   in_rs1_idx, in_rs1_data       source 1 index and register data
//   in_rs2_idx, in_rs2_data       source 2 index and register data
//   in_imm, in_use_imm            immediate and B-operand select
//   in_sub, in_rd                 add/sub select, destination (0 = none)
//   add_a, add_b, add_m           registered adder operands and mode
//   add_sum                       combinational adder result
//   res_valid / res_ready         writeback-side handshake
//   res_data, res_rd              captured sum and its destination
//   fwd_count                     saturating count of forwarded accepts
// Revision : 1.0 - initial release
//==============================================================================
module addsub_issue_stage #(
   parameter int FWD_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   // decode side
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_rs1_idx,
   input  logic [4:0]           in_rs2_idx,
   input  logic [31:0]          in_rs1_data,
   input  logic [31:0]          in_rs2_data,
   input  logic [31:0]          in_imm,
   input  logic                 in_use_imm,
   input  logic                 in_sub,
   input  logic [4:0]           in_rd,
   // adder interface
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   output logic                 add_m,
   input  logic [31:0]          add_sum,
   // writeback side
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_data,
   output logic [4:0]           res_rd,
   // statistics
   output logic [FWD_CNT_W-1:0] fwd_count
);

   localparam logic [FWD_CNT_W-1:0] CNT_MAX = {FWD_CNT_W{1'b1}};

   // E-stage bookkeeping that is not directly a port
   logic       e_valid;
   logic [4:0] e_rd;

   // handshake / advance
   logic r_free;
   logic e_adv;
   logic accept;

   // forwarding
   logic        e_hit_a, r_hit_a;
   logic        e_hit_b, r_hit_b;
   logic        fwd_a, fwd_b, fwd_used;
   logic [31:0] op_a, op_b;

   //---------------------------------------------------------------------------
   // Advance conditions. in_ready depends only on pipeline state and
   // res_ready, never on in_valid.
   //---------------------------------------------------------------------------
   assign r_free   = !res_valid || res_ready;
   assign e_adv    = e_valid && r_free;
   assign in_ready = !e_valid || e_adv;
   assign accept   = in_valid && in_ready;

   //---------------------------------------------------------------------------
   // Forwarding match. Register 0 is hard-wired zero and never forwarded.
   // E holds the youngest producer, so an E hit outranks an R hit. The live
   // adder output is correct to forward even if E advances this cycle, since
   // R will capture the same value.
   //---------------------------------------------------------------------------
   assign e_hit_a = e_valid   && (e_rd   != 5'd0) && (e_rd   == in_rs1_idx);
   assign r_hit_a = res_valid && (res_rd != 5'd0) && (res_rd == in_rs1_idx);
   assign e_hit_b = e_valid   && (e_rd   != 5'd0) && (e_rd   == in_rs2_idx);
   assign r_hit_b = res_valid && (res_rd != 5'd0) && (res_rd == in_rs2_idx);

   always_comb begin
      op_a  = in_rs1_data;
      fwd_a = 1'b0;
      if (e_hit_a) begin
         op_a  = add_sum;
         fwd_a = 1'b1;
      end else if (r_hit_a) begin
         op_a  = res_data;
         fwd_a = 1'b1;
      end
   end

   // With an immediate B operand, rs2 is ignored entirely, including for
   // the forwarding statistic.
   always_comb begin
      op_b  = in_rs2_data;
      fwd_b = 1'b0;
      if (in_use_imm) begin
         op_b = in_imm;
      end else if (e_hit_b) begin
         op_b  = add_sum;
         fwd_b = 1'b1;
      end else if (r_hit_b) begin
         op_b  = res_data;
         fwd_b = 1'b1;
      end
   end

   assign fwd_used = fwd_a || fwd_b;

   //---------------------------------------------------------------------------
   // E stage. Registers only load on accept; otherwise they hold, which keeps
   // the adder inputs stable under backpressure and while empty.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_valid <= 1'b0;
         add_a   <= 32'd0;
         add_b   <= 32'd0;
         add_m   <= 1'b0;
         e_rd    <= 5'd0;
      end else if (accept) begin
         e_valid <= 1'b1;
         add_a   <= op_a;
         add_b   <= op_b;
         add_m   <= in_sub;
         e_rd    <= in_rd;
      end else if (e_adv) begin
         e_valid <= 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // R stage. Capturing from E takes priority over draining, which gives a
   // bubble-free drain-and-refill when both stages are full.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= 32'd0;
         res_rd    <= 5'd0;
      end else if (e_adv) begin
         res_valid <= 1'b1;
         res_data  <= add_sum;
         res_rd    <= e_rd;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // Forwarding-event counter, saturating at all-ones.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_count <= '0;
      end else if (accept && fwd_used && (fwd_count != CNT_MAX)) begin
         fwd_count <= fwd_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_addsub_issue_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_addsub_issue_stage
// Purpose  : Directed self-checking bench for addsub_issue_stage. An ideal
//            adder model closes the adder loop. A second instance with a
//            2-bit forwarding counter shares all stimulus for saturation.
// Revision : 1.0 - initial release
//==============================================================================
module tb_addsub_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic        in_use_imm, in_sub;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_m;
   logic [31:0] add_a2, add_b2, add_sum2;
   logic        add_m2;
   logic        res_valid, res_valid2;
   logic        res_ready;
   logic [31:0] res_data, res_data2;
   logic [4:0]  res_rd, res_rd2;
   logic [15:0] fwd_count;
   logic [1:0]  fwd_count2;

   int checks = 0;
   int errors = 0;

   // consumed-result log
   logic        mon_en = 1'b0;
   logic [31:0] drained[$];

   // ideal adders
   assign add_sum  = add_m  ? (add_a  - add_b)  : (add_a  + add_b);
   assign add_sum2 = add_m2 ? (add_a2 - add_b2) : (add_a2 + add_b2);

   addsub_issue_stage #(.FWD_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sub(in_sub), .in_rd(in_rd),
      .add_a(add_a), .add_b(add_b), .add_m(add_m), .add_sum(add_sum),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_rd(res_rd), .fwd_count(fwd_count)
   );

   addsub_issue_stage #(.FWD_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sub(in_sub), .in_rd(in_rd),
      .add_a(add_a2), .add_b(add_b2), .add_m(add_m2), .add_sum(add_sum2),
      .res_valid(res_valid2), .res_ready(res_ready),
      .res_data(res_data2), .res_rd(res_rd2), .fwd_count(fwd_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mon_en && rst_n && res_valid && res_ready) drained.push_back(res_data);
   end

   // advance one edge, then settle away from it
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [4:0] r1i, input logic [31:0] r1d,
                           input logic [4:0] r2i, input logic [31:0] r2d,
                           input logic use_imm, input logic [31:0] imm,
                           input logic sub, input logic [4:0] rd);
      in_valid    = 1'b1;
      in_rs1_idx  = r1i;
      in_rs1_data = r1d;
      in_rs2_idx  = r2i;
      in_rs2_data = r2d;
      in_use_imm  = use_imm;
      in_imm      = imm;
      in_sub      = sub;
      in_rd       = rd;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      res_ready = 1'b1;
      drive_op(5'd3, 32'd11, 5'd4, 32'd22, 1'b0, 32'd0, 1'b1, 5'd7);
      cycle();
      cycle();
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
      checks++;
      if ({add_a, add_b, add_m} !== 65'd0) begin errors++; $display("FAIL reset_add: got a=%0h b=%0h m=%0b expected 0", add_a, add_b, add_m); end
      checks++;
      if ({res_data, res_rd} !== 37'd0) begin errors++; $display("FAIL reset_res: got data=%0h rd=%0d expected 0", res_data, res_rd); end
      checks++;
      if (fwd_count !== 16'd0 || fwd_count2 !== 2'd0) begin errors++; $display("FAIL reset_fwd_count: got %0d/%0d expected 0", fwd_count, fwd_count2); end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      cycle();
      checks++;
      if (res_valid !== 1'b0 || add_a !== 32'd0) begin errors++; $display("FAIL reset_no_accept: got res_valid=%0b add_a=%0d expected 0/0", res_valid, add_a); end
   endtask

   task automatic test_basic_add();
      drive_op(5'd10, 32'd5, 5'd11, 32'd3, 1'b0, 32'd0, 1'b0, 5'd1);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd5 || add_b !== 32'd3 || add_m !== 1'b0) begin errors++; $display("FAIL basic_operands: got a=%0d b=%0d m=%0b expected 5 3 0", add_a, add_b, add_m); end
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got res_valid=%0b expected 0", res_valid); end
      cycle();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd8 || res_rd !== 5'd1) begin errors++; $display("FAIL basic_result: got v=%0b data=%0d rd=%0d expected 1 8 1", res_valid, res_data, res_rd); end
      cycle();
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got res_valid=%0b expected 0", res_valid); end
   endtask

   task automatic test_sub_imm();
      drive_op(5'd12, 32'd10, 5'd13, 32'd99, 1'b1, 32'd4, 1'b1, 5'd2);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd10 || add_b !== 32'd4 || add_m !== 1'b1) begin errors++; $display("FAIL subimm_operands: got a=%0d b=%0d m=%0b expected 10 4 1", add_a, add_b, add_m); end
      cycle();
      checks++;
      if (res_data !== 32'd6 || res_rd !== 5'd2) begin errors++; $display("FAIL subimm_result: got data=%0d rd=%0d expected 6 2", res_data, res_rd); end
      idle(2);
   endtask

   task automatic test_forwarding();
      // x1 = 2 + 3, then x2 = x1 + x1 with stale register data
      drive_op(5'd20, 32'd2, 5'd21, 32'd3, 1'b0, 32'd0, 1'b0, 5'd1);
      cycle();
      drive_op(5'd1, 32'd0, 5'd1, 32'd0, 1'b0, 32'd0, 1'b0, 5'd2);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd5 || add_b !== 32'd5) begin errors++; $display("FAIL fwd_e_operands: got a=%0d b=%0d expected 5 5", add_a, add_b); end
      checks++;
      if (fwd_count !== 16'd1) begin errors++; $display("FAIL fwd_e_count: got %0d expected 1", fwd_count); end
      cycle();
      checks++;
      if (res_data !== 32'd10 || res_rd !== 5'd2) begin errors++; $display("FAIL fwd_e_result: got data=%0d rd=%0d expected 10 2", res_data, res_rd); end
      idle(2);

      // same shape with rd = 0 and sources reading x0: no forwarding
      drive_op(5'd20, 32'd2, 5'd21, 32'd3, 1'b0, 32'd0, 1'b0, 5'd0);
      cycle();
      drive_op(5'd0, 32'd7, 5'd0, 32'd8, 1'b0, 32'd0, 1'b0, 5'd3);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd7 || add_b !== 32'd8 || fwd_count !== 16'd1) begin errors++; $display("FAIL fwd_rd0: got a=%0d b=%0d cnt=%0d expected 7 8 1", add_a, add_b, fwd_count); end
      cycle();
      checks++;
      if (res_data !== 32'd15) begin errors++; $display("FAIL fwd_rd0_result: got %0d expected 15", res_data); end
      idle(2);

      // forward from R while R is being consumed the same cycle
      drive_op(5'd20, 32'd2, 5'd21, 32'd3, 1'b0, 32'd0, 1'b0, 5'd4);
      cycle();
      in_valid = 1'b0;
      cycle();
      drive_op(5'd4, 32'd0, 5'd30, 32'd1, 1'b0, 32'd0, 1'b0, 5'd6);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd5 || add_b !== 32'd1 || fwd_count !== 16'd2) begin errors++; $display("FAIL fwd_r: got a=%0d b=%0d cnt=%0d expected 5 1 2", add_a, add_b, fwd_count); end
      idle(2);

      // E (20) outranks R (2) for the same destination
      drive_op(5'd20, 32'd1, 5'd21, 32'd1, 1'b0, 32'd0, 1'b0, 5'd5);
      cycle();
      drive_op(5'd20, 32'd10, 5'd21, 32'd10, 1'b0, 32'd0, 1'b0, 5'd5);
      cycle();
      drive_op(5'd5, 32'd0, 5'd5, 32'd0, 1'b0, 32'd0, 1'b1, 5'd7);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (add_a !== 32'd20 || add_b !== 32'd20 || add_m !== 1'b1) begin errors++; $display("FAIL fwd_priority: got a=%0d b=%0d m=%0b expected 20 20 1", add_a, add_b, add_m); end
      checks++;
      if (fwd_count !== 16'd3) begin errors++; $display("FAIL fwd_priority_count: got %0d expected 3", fwd_count); end
      cycle();
      checks++;
      if (res_data !== 32'd0 || res_rd !== 5'd7) begin errors++; $display("FAIL fwd_priority_result: got data=%0d rd=%0d expected 0 7", res_data, res_rd); end
      idle(2);
   endtask

   task automatic test_backpressure();
      int acc;
      drained.delete();
      mon_en    = 1'b1;
      res_ready = 1'b0;
      acc       = 0;
      // three independent ops A=1+2 (x6), B=3+4 (x7), C=5+6 (x8)
      drive_op(5'd20, 32'd1, 5'd21, 32'd2, 1'b0, 32'd0, 1'b0, 5'd6);
      if (in_ready) acc++;
      cycle();
      drive_op(5'd20, 32'd3, 5'd21, 32'd4, 1'b0, 32'd0, 1'b0, 5'd7);
      if (in_ready) acc++;
      cycle();
      drive_op(5'd20, 32'd5, 5'd21, 32'd6, 1'b0, 32'd0, 1'b0, 5'd8);
      for (int i = 0; i < 3; i++) begin
         if (in_ready) acc++;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_c%0d: got %0b expected 0", i, in_ready); end
         checks++;
         if (add_a !== 32'd3 || add_b !== 32'd4 || res_valid !== 1'b1 || res_data !== 32'd3 || res_rd !== 5'd6) begin
            errors++;
            $display("FAIL bp_hold_c%0d: got a=%0d b=%0d v=%0b data=%0d rd=%0d expected 3 4 1 3 6", i, add_a, add_b, res_valid, res_data, res_rd);
         end
         cycle();
      end
      checks++;
      if (acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
      // release: drain A, R takes B, E takes C at one edge
      res_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
      cycle();
      in_valid = 1'b0;
      checks++;
      if (res_data !== 32'd7 || res_rd !== 5'd7 || add_a !== 32'd5 || add_b !== 32'd6) begin
         errors++;
         $display("FAIL bp_refill: got data=%0d rd=%0d a=%0d b=%0d expected 7 7 5 6", res_data, res_rd, add_a, add_b);
      end
      idle(4);
      mon_en = 1'b0;
      checks++;
      if (drained.size() !== 3) begin errors++; $display("FAIL bp_drain_count: got %0d expected 3", drained.size()); end
      else begin
         checks++;
         if (drained[0] !== 32'd3 || drained[1] !== 32'd7 || drained[2] !== 32'd11) begin
            errors++;
            $display("FAIL bp_drain_order: got %0d %0d %0d expected 3 7 11", drained[0], drained[1], drained[2]);
         end
      end
   endtask

   task automatic test_saturation_and_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      cycle();
      rst_n = 1'b1;
      checks++;
      if (fwd_count !== 16'd0 || fwd_count2 !== 2'd0) begin errors++; $display("FAIL sat_cleared: got %0d/%0d expected 0", fwd_count, fwd_count2); end
      // x1 = 1+1, then five dependent x1 = x1 + 1 back to back
      drive_op(5'd20, 32'd1, 5'd21, 32'd1, 1'b0, 32'd0, 1'b0, 5'd1);
      cycle();
      for (int i = 0; i < 5; i++) begin
         drive_op(5'd1, 32'd0, 5'd21, 32'd1, 1'b0, 32'd0, 1'b0, 5'd1);
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0b expected 1", i, in_ready); end
         cycle();
      end
      in_valid = 1'b0;
      checks++;
      if (fwd_count !== 16'd5) begin errors++; $display("FAIL sat_count16: got %0d expected 5", fwd_count); end
      checks++;
      if (fwd_count2 !== 2'd3) begin errors++; $display("FAIL sat_count2: got %0d expected 3", fwd_count2); end
      cycle();
      checks++;
      if (res_data !== 32'd7 || res_data2 !== 32'd7) begin errors++; $display("FAIL b2b_result: got %0d/%0d expected 7", res_data, res_data2); end
      idle(2);

      // fill E and R, then reset while full
      res_ready = 1'b0;
      drive_op(5'd20, 32'd100, 5'd21, 32'd1, 1'b0, 32'd0, 1'b0, 5'd9);
      cycle();
      drive_op(5'd20, 32'd200, 5'd21, 32'd1, 1'b0, 32'd0, 1'b0, 5'd10);
      cycle();
      in_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got v=%0b ready=%0b expected 1 0", res_valid, in_ready); end
      rst_n = 1'b0;
      cycle();
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_valid2 !== 1'b0) begin errors++; $display("FAIL mid_reset: got v=%0b ready=%0b v2=%0b expected 0 1 0", res_valid, in_ready, res_valid2); end
      rst_n = 1'b1;
      res_ready = 1'b1;
      drained.delete();
      mon_en = 1'b1;
      idle(4);
      mon_en = 1'b0;
      checks++;
      if (drained.size() !== 0) begin errors++; $display("FAIL mid_reset_dropped: got %0d results expected 0", drained.size()); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
      in_rs1_idx = '0; in_rs2_idx = '0; in_rd = '0;
      in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
      in_use_imm = 1'b0; in_sub = 1'b0;
      #2;
      test_reset();
      test_basic_add();
      test_sub_imm();
      test_forwarding();
      test_backpressure();
      test_saturation_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // absolute time bound so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/addsub_issue_stage.md
# addsub_issue_stage

Operand-issue and result-capture stage wrapped around the combinational 32-bit adder/subtractor in the CPU execute path. It accepts decoded add/sub operations from the decode stage over a valid/ready handshake and selects register or immediate operands. It forwards results from in-flight operations, presents registered `add_a`/`add_b`/`add_m` to the adder, and captures `add_sum` into a result register for writeback. It holds two pipeline stages: E (operands to the adder) and R (captured result).

## Interface
- `FWD_CNT_W`, 16, width of the saturating forwarding-event counter.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  decode offers an operation.
- `in_ready`  out  1  stage accepts the operation this cycle.
- `in_rs1_idx`, `in_rs2_idx`  in  5 each  source register indices.
- `in_rs1_data`, `in_rs2_data`  in  32 each  register-file read data.
- `in_imm`  in  32  sign-extended immediate.
- `in_use_imm`  in  1  1: B operand is `in_imm`, and rs2 is ignored.
- `in_sub`  in  1  1: subtract, 0: add.
- `in_rd`  in  5  destination register index; 0 means no writeback.
- `add_a`, `add_b`  out  32 each  registered adder operands.
- `add_m`  out  1  registered add/sub select.
- `add_sum`  in  32  combinational adder result for the current `add_a`/`add_b`/`add_m`.
- `res_valid`  out  1  R holds a result.
- `res_ready`  in  1  writeback consumes the result.
- `res_data`  out  32  captured sum.
- `res_rd`  out  5  destination of `res_data`.
- `fwd_count`  out  FWD_CNT_W  number of accepted operations that used at least one forwarded operand; saturates at all-ones.

## Operation
- State:
  - E: `e_valid`, `add_a`, `add_b`, `add_m`, `e_rd`.
  - R: `res_valid`, `res_data`, `res_rd`.
- Advance conditions:
  - `r_free = !res_valid || res_ready`.
  - `e_adv = e_valid && r_free`.
  - `in_ready = !e_valid || e_adv`. This is combinational from `res_ready`; there is no path from `in_valid` to `in_ready`.
- Accept: `in_valid && in_ready`. Load E with the selected operands, `add_m <= in_sub`, `e_rd <= in_rd`, `e_valid <= 1`.
- Operand A, by priority:
  1. `add_sum` if `e_valid && e_rd != 0 && e_rd == in_rs1_idx` (youngest producer wins).
  2. Otherwise `res_data` if `res_valid && res_rd != 0 && res_rd == in_rs1_idx`.
  3. Otherwise `in_rs1_data`.
- Operand B: `in_imm` if `in_use_imm`; otherwise the same forwarding rule applied to `in_rs2_idx`/`in_rs2_data`.
- Index 0 is never forwarded.
- Forwarding from E applies even when E advances in the same cycle, because the value is identical.
- Forwarding from R applies even when `res_ready` is high in the same cycle.
- E advance: `res_data <= add_sum`, `res_rd <= e_rd`, `res_valid <= 1`. If there is no accept in the same cycle, `e_valid <= 0`.
- R drain: if `res_valid && res_ready && !e_adv`, then `res_valid <= 0`.
- E register hold: when `e_valid` and `!e_adv`, E registers hold and `add_a`/`add_b`/`add_m` stay stable.
- E register when empty: while `e_valid` = 0, E registers keep their last values.
- `fwd_count` increments by 1 on an accept where A or B came from E or R. It saturates and never wraps.
- Arithmetic is entirely inside the adder. This block does not modify, extend or check `add_sum`; it captures all 32 bits verbatim.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - `e_valid`, `res_valid` = 0.
  - `add_a`, `add_b`, `res_data` = 0; `add_m` = 0; `e_rd`, `res_rd` = 0; `fwd_count` = 0.
  - In-flight operations are discarded.
  - `in_ready` = 1 in the first cycle after reset.
- Latency: accepted at edge N, the operation drives the adder during cycle N+1, and `res_valid` = 1 from edge N+1 if R was free.
- Throughput: one operation per cycle while `res_ready` = 1.
- Full (E and R both valid, `res_ready` = 0): `in_ready` = 0, all state holds, and R stays stable.
- Simultaneous drain and refill: when `res_ready` = 1 and `in_valid` = 1 with both stages full, R takes E and E takes the new operation at the same edge, with no bubble.
- Back-to-back dependent operations need no stall.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 -> no accept; all outputs 0; `in_ready` = 1 after release.
- Basic: accept add with rs1 data = 5, rs2 data = 3, rd = 1 -> next cycle `add_a` = 5, `add_b` = 3, `add_m` = 0; with an ideal adder model, one cycle later `res_data` = 8, `res_rd` = 1.
- Subtract with immediate: rs1 data = 10, `in_use_imm` = 1, imm = 4, `in_sub` = 1 -> `add_b` = 4, `add_m` = 1, `res_data` = 6.
- Forwarding: issue back-to-back x1 = 2+3 then x2 = x1+x1 with stale register data 0 -> second operation sees `add_a` = `add_b` = 5, `res_data` = 10, `fwd_count` = 1.
  - Repeat with rd = 0 -> no forwarding and `fwd_count` unchanged.
- Backpressure: `res_ready` = 0 for 5 cycles with 3 operations offered -> only 2 accepted; `in_ready` = 0 while full; `add_*` and `res_*` stable.
  - Then `res_ready` = 1 -> results drain in order with no loss or duplication.
- Saturation and mid-operation reset:
  - With `FWD_CNT_W` = 2, 5 forwarded operations -> `fwd_count` = 3.
  - Assert `rst_n` = 0 while E and R are full -> both valids are 0 the next cycle, and the dropped results never appear.
